// File: rtl/pll_sup_pkg.sv
// ============================================================================
// pll_sup_pkg
// Shared types and helpers for the PLL lock supervisor.
//   ch_state_e : per-channel sequencing state
//   cnt_w()    : counter width needed to hold values 0..max
//   LOSS_CNT_W : width of each channel's lock-loss counter
// ============================================================================
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } ch_state_e;

    localparam int LOSS_CNT_W = 8;

    // Width of a counter that must reach 'max' inclusive.
    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage : pll_sup_pkg

// File: rtl/pll_lock_ch.sv
// ============================================================================
// pll_lock_ch
// One supervised rPLL channel: lock synchroniser, sequencing FSM, shared
// hold/timeout/stable counter, retry counter and optional lock-loss counter.
//
// Optional feature macro: PLL_LOSS_COUNT_EN (builds the saturating loss
// counter; otherwise loss_cnt_o is tied to zero).
//
// Ports
//   clk          in   reference clock
//   resetn       in   synchronous active-low reset
//   lock_i       in   raw rPLL LOCK, asynchronous to clk
//   retry_i      in   one-cycle pulse, restarts the channel when in FAIL
//   pll_reset_o  out  rPLL RESET drive, active-high
//   ch_locked_o  out  channel has a debounced lock
//   fail_o       out  retries exhausted
//   loss_cnt_o   out  number of lock-loss events, saturating
// ============================================================================
module pll_lock_ch
    import pll_sup_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES   = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 270000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  lock_i,
    input  logic                  retry_i,
    output logic                  pll_reset_o,
    output logic                  ch_locked_o,
    output logic                  fail_o,
    output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

    // One counter serves all timed states, so it is sized for the largest
    // terminal value among them.
    localparam int HOLD_MAX  = RESET_HOLD_CYCLES - 1;
    localparam int STAB_MAX  = LOCK_STABLE_CYCLES - 1;
    localparam int TMO_MAX   = LOCK_TIMEOUT_CYCLES - 1;
    localparam int MAX_AB    = (HOLD_MAX > STAB_MAX) ? HOLD_MAX : STAB_MAX;
    localparam int CNT_MAX   = (MAX_AB > TMO_MAX) ? MAX_AB : TMO_MAX;
    localparam int CNT_W_RAW = cnt_w(CNT_MAX);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam int RTY_W_RAW = cnt_w(MAX_RETRIES);
    localparam int RTY_W     = (RTY_W_RAW < 1) ? 1 : RTY_W_RAW;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STAB_MAX);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_MAX);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [RTY_W-1:0] RTY_LAST  = RTY_W'(MAX_RETRIES);
    localparam logic [RTY_W-1:0] RTY_ZERO  = {RTY_W{1'b0}};
    localparam logic [RTY_W-1:0] RTY_ONE   = RTY_W'(1'b1);

    logic [1:0]       sync_q,      sync_d;
    ch_state_e        state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [RTY_W-1:0] retry_q,     retry_d;
    logic             pll_reset_q, pll_reset_d;
    logic             ch_locked_q, ch_locked_d;
    logic             fail_q,      fail_d;
    logic             lock_s;

    // Two-stage synchroniser for the asynchronous LOCK input.
    always_comb begin
        sync_d = {sync_q[0], lock_i};
    end

    assign lock_s = sync_q[1];

    // Next-state, counter and retry logic for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        case (state_q)
            ST_RESET: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT: begin
                // A lock seen in the timeout cycle still wins.
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (retry_q == RTY_LAST) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_RESET;
                        retry_d = retry_q + RTY_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STABLE: begin
                // A dropout restarts the timeout but keeps the retry budget.
                if (!lock_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = ST_LOCKED;
                    cnt_d   = CNT_ZERO;
                    retry_d = RTY_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LOCKED: begin
                if (!lock_s) begin
                    state_d = ST_RESET;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_FAIL: begin
                if (retry_i) begin
                    state_d = ST_RESET;
                    cnt_d   = CNT_ZERO;
                    retry_d = RTY_ZERO;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = CNT_ZERO;
                retry_d = RTY_ZERO;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register and come straight from flops.
    always_comb begin
        pll_reset_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
        ch_locked_d = (state_d == ST_LOCKED);
        fail_d      = (state_d == ST_FAIL);
    end

    // State, counter, synchroniser and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q      <= 2'b00;
            state_q     <= ST_RESET;
            cnt_q       <= CNT_ZERO;
            retry_q     <= RTY_ZERO;
            pll_reset_q <= 1'b1;
            ch_locked_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            ch_locked_q <= ch_locked_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_reset_o = pll_reset_q;
    assign ch_locked_o = ch_locked_q;
    assign fail_o      = fail_q;

`ifdef PLL_LOSS_COUNT_EN
    logic                  loss_evt_s;
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    // A loss event is exactly the LOCKED -> RESET transition.
    assign loss_evt_s = (state_q == ST_LOCKED) && !lock_s;

    // Saturating increment of the loss count.
    always_comb begin
        if (loss_evt_s && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1'b1);
        end else begin
            loss_cnt_d = loss_cnt_q;
        end
    end

    // Loss counter register, cleared only by resetn.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            loss_cnt_q <= {LOSS_CNT_W{1'b0}};
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt_o = loss_cnt_q;
`else
    assign loss_cnt_o = {LOSS_CNT_W{1'b0}};
`endif

endmodule : pll_lock_ch

// File: rtl/pll_lock_supervisor.sv
// ============================================================================
// pll_lock_supervisor
// Sequences and supervises NUM_PLL rPLL instances from the reference clock
// domain and releases the downstream system reset once all are stable.
//
// Optional feature macro: PLL_LOSS_COUNT_EN (per-channel saturating
// lock-loss counters on loss_cnt_o; zero when undefined).
//
// Ports
//   clk           in   reference clock
//   resetn        in   synchronous active-low reset
//   pll_lock_i    in   [NUM_PLL]    raw rPLL LOCK outputs (asynchronous)
//   retry_i       in   pulse, restarts every channel in FAIL
//   pll_reset_o   out  [NUM_PLL]    rPLL RESET drive, active-high
//   ch_locked_o   out  [NUM_PLL]    per-channel stable lock
//   fail_o        out  [NUM_PLL]    per-channel retries exhausted
//   all_locked_o  out  registered AND of ch_locked_o
//   sys_resetn_o  out  downstream active-low reset (all_locked_o delayed)
//   loss_cnt_o    out  [8*NUM_PLL]  lock-loss counts, channel i at [8i+7:8i]
// ============================================================================
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_PLL             = 2,
    parameter int RESET_HOLD_CYCLES   = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 270000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [NUM_PLL-1:0]               pll_lock_i,
    input  logic                             retry_i,
    output logic [NUM_PLL-1:0]               pll_reset_o,
    output logic [NUM_PLL-1:0]               ch_locked_o,
    output logic [NUM_PLL-1:0]               fail_o,
    output logic                             all_locked_o,
    output logic                             sys_resetn_o,
    output logic [LOSS_CNT_W*NUM_PLL-1:0]    loss_cnt_o
);

    logic all_locked_q, all_locked_d;
    logic sys_resetn_q, sys_resetn_d;

    for (genvar g = 0; g < NUM_PLL; g++) begin : g_ch
        pll_lock_ch #(
            .RESET_HOLD_CYCLES  (RESET_HOLD_CYCLES),
            .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
            .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
            .MAX_RETRIES        (MAX_RETRIES)
        ) u_ch (
            .clk        (clk),
            .resetn     (resetn),
            .lock_i     (pll_lock_i[g]),
            .retry_i    (retry_i),
            .pll_reset_o(pll_reset_o[g]),
            .ch_locked_o(ch_locked_o[g]),
            .fail_o     (fail_o[g]),
            .loss_cnt_o (loss_cnt_o[LOSS_CNT_W*g +: LOSS_CNT_W])
        );
    end

    // The system reset only follows the all-locked flag, one cycle later,
    // so it can never release ahead of every channel being locked.
    always_comb begin
        all_locked_d = &ch_locked_o;
        sys_resetn_d = all_locked_q;
    end

    // Aggregate status registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            all_locked_q <= 1'b0;
            sys_resetn_q <= 1'b0;
        end else begin
            all_locked_q <= all_locked_d;
            sys_resetn_q <= sys_resetn_d;
        end
    end

    assign all_locked_o = all_locked_q;
    assign sys_resetn_o = sys_resetn_q;

endmodule : pll_lock_supervisor
